// File: rtl/led_event_stretcher_pkg.sv
// Shared constants for the LED event stretcher: state encodings,
// board clock rate and the millisecond-to-cycle helper.
package led_event_stretcher_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_ON   = 2'd1;
  localparam state_t ST_GAP  = 2'd2;

  localparam int unsigned CLK_HZ = 25_000_000;

  function automatic int unsigned ms_to_cycles(input int unsigned ms);
    return (CLK_HZ / 1000) * ms;
  endfunction

endpackage

// File: rtl/led_event_stretcher.sv
// Stretches single-cycle events into visible LED pulses with a dark gap,
// queueing events that arrive mid-pulse in a saturating counter.
module led_event_stretcher
  import led_event_stretcher_pkg::*;
#(
  parameter int unsigned ON_COUNT  = ms_to_cycles(100),
  parameter int unsigned GAP_COUNT = ms_to_cycles(50),
  parameter int unsigned PEND_MAX  = 7
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Event,
  output logic o_LED,
  output logic o_Busy,
  output logic o_Overflow
);

  localparam int unsigned CMAX =
    (ON_COUNT > GAP_COUNT) ? ON_COUNT : GAP_COUNT;
  localparam int unsigned CW = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int unsigned PW = $clog2(PEND_MAX + 1);

  localparam logic [CW-1:0] ON_LAST  = CW'(ON_COUNT - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_COUNT - 1);
  localparam logic [PW-1:0] P_MAX    = PW'(PEND_MAX);

  state_t        r_State;
  logic [CW-1:0] r_Count;
  logic [PW-1:0] r_Pend;
  logic          r_LED;
  logic          r_Overflow;

  state_t        w_State;
  logic [CW-1:0] w_Count;
  logic [PW-1:0] w_Pend;
  logic          w_Queue;
  logic          w_Overflow;

  always_comb begin
    w_State    = r_State;
    w_Count    = r_Count;
    w_Pend     = r_Pend;
    w_Queue    = 1'b0;
    w_Overflow = 1'b0;
    case (r_State)
      ST_IDLE: begin
        w_Count = '0;
        // A fresh event starts directly; otherwise replay a queued one.
        if (i_Event) begin
          w_State = ST_ON;
        end else if (r_Pend != '0) begin
          w_State = ST_ON;
          w_Pend  = r_Pend - PW'(1);
        end
      end
      ST_ON: begin
        w_Queue = 1'b1;
        if (r_Count == ON_LAST) begin
          w_State = ST_GAP;
          w_Count = '0;
        end else begin
          w_Count = r_Count + CW'(1);
        end
      end
      ST_GAP: begin
        w_Queue = 1'b1;
        if (r_Count == GAP_LAST) begin
          w_State = ST_IDLE;
          w_Count = '0;
        end else begin
          w_Count = r_Count + CW'(1);
        end
      end
      default: begin
        w_State = ST_IDLE;
        w_Count = '0;
      end
    endcase
    if (w_Queue && i_Event) begin
      if (r_Pend < P_MAX) begin
        w_Pend = r_Pend + PW'(1);
      end else begin
        w_Overflow = 1'b1;
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_State    <= ST_IDLE;
      r_Count    <= '0;
      r_Pend     <= '0;
      r_LED      <= 1'b0;
      r_Overflow <= 1'b0;
    end else begin
      r_State    <= w_State;
      r_Count    <= w_Count;
      r_Pend     <= w_Pend;
      r_LED      <= (w_State == ST_ON);
      r_Overflow <= w_Overflow;
    end
  end

  assign o_LED      = r_LED;
  assign o_Overflow = r_Overflow;
  assign o_Busy     = (r_State != ST_IDLE) || (r_Pend != '0);

endmodule

// File: tb/tb_led_event_stretcher.sv
// Randomised and directed bench for led_event_stretcher, checked by a
// timeline model of pulse scheduling through a per-cycle scoreboard.
module tb_led_event_stretcher;

  localparam int ON   = 4;
  localparam int GAP  = 3;
  localparam int PMAX = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ev  = 1'b0;
  logic led, busy, ovf;

  led_event_stretcher #(
    .ON_COUNT (ON),
    .GAP_COUNT(GAP),
    .PEND_MAX (PMAX)
  ) dut (
    .i_Clk     (clk),
    .i_Rst     (rst),
    .i_Event   (ev),
    .o_LED     (led),
    .o_Busy    (busy),
    .o_Overflow(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   cyc;
    logic led;
    logic busy;
    logic ovf;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Model: a pulse lights cycles [m_s, m_s+ON); the machine can accept a
  // new start from cycle m_free on; m_wait counts events still owed.
  int m_s     = -1000;
  int m_free  = 0;
  int m_wait  = 0;
  bit m_ovf   = 1'b0;

  function automatic void chk(input string nm, input int c,
                              input logic got, input logic want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s cycle=%0d got=%b expected=%b", nm, c, got, want);
  endfunction

  task automatic step(input logic e, input logic r);
    int   t;
    exp_t x;
    @(posedge clk);
    #1;
    ev  = e;
    rst = r;
    t   = cyc;
    m_ovf = 1'b0;
    if (r) begin
      m_s    = -1000;
      m_free = t + 1;
      m_wait = 0;
    end else if (t >= m_free) begin
      if (e || m_wait > 0) begin
        if (!e) m_wait--;
        m_s    = t + 1;
        m_free = t + 1 + ON + GAP;
      end
    end else if (e) begin
      if (m_wait < PMAX) m_wait++;
      else m_ovf = 1'b1;
    end
    x.cyc  = t + 1;
    x.led  = (t + 1 >= m_s) && (t + 1 < m_s + ON);
    x.busy = (t + 1 < m_free) || (m_wait != 0);
    x.ovf  = m_ovf;
    sb.push_back(x);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    exp_t y;
    while (sb.size() != 0 && sb[0].cyc < cyc) begin
      y = sb.pop_front();
      n_chk++;
      $display("FAIL stale_entry cycle=%0d got=unchecked expected=cycle %0d",
               cyc, y.cyc);
    end
    if (sb.size() != 0 && sb[0].cyc == cyc) begin
      y = sb.pop_front();
      chk("led",      cyc, led,  y.led);
      chk("busy",     cyc, busy, y.busy);
      chk("overflow", cyc, ovf,  y.ovf);
    end
  end

  initial begin
    int p;
    // reset, then single event
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    idle(8);
    step(1'b1, 1'b0);
    idle(14);
    // back-to-back
    step(1'b1, 1'b0);
    idle(1);
    step(1'b1, 1'b0);
    idle(20);
    // overflow
    repeat (4) step(1'b1, 1'b0);
    idle(30);
    // event on the last gap cycle
    step(1'b1, 1'b0);
    idle(6);
    step(1'b1, 1'b0);
    idle(16);
    // event in IDLE while one is pending
    step(1'b1, 1'b0);
    idle(1);
    step(1'b1, 1'b0);
    idle(5);
    step(1'b1, 1'b0);
    idle(30);
    // reset mid-pulse
    step(1'b1, 1'b0);
    idle(1);
    step(1'b0, 1'b1);
    idle(1);
    step(1'b1, 1'b0);
    idle(12);
    // random load at varying densities with occasional resets
    for (int b = 0; b < 12; b++) begin
      p = $urandom_range(3, 70);
      for (int i = 0; i < 200; i++) begin
        step($urandom_range(0, 99) < p,
             $urandom_range(0, 299) == 0);
      end
    end
    idle(40);
    repeat (3) @(posedge clk);
    n_chk++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL drain cycle=%0d got=%0d left expected=0",
                  cyc, sb.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
